// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the two writeback sources and the register file write port.
// Parameters must match those of the rf_wb_arbiter instance it connects to.
interface rf_wb_arbiter_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          s0_valid;
  logic          s0_ready;
  logic [AW-1:0] s0_addr;
  logic [DW-1:0] s0_data;

  logic          s1_valid;
  logic          s1_ready;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_data;

  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [CW-1:0] s0_count;
  logic [CW-1:0] s1_count;
  logic          idle;

  modport master (
    output s0_valid, s0_addr, s0_data,
    output s1_valid, s1_addr, s1_data,
    input  s0_ready, s1_ready,
    input  we, wa, wd, s0_count, s1_count, idle
  );

  modport slave (
    input  s0_valid, s0_addr, s0_data,
    input  s1_valid, s1_addr, s1_data,
    output s0_ready, s1_ready,
    output we, wa, wd, s0_count, s1_count, idle
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-source writeback arbiter: per-source FIFOs feeding a registered register-file write port.
// Define WB_RR_EN for round-robin on contention; default is fixed priority (source 0 wins).
module rf_wb_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input logic           clk,
  input logic           rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = AW + DW;

  typedef enum logic {SRC0 = 1'b0, SRC1 = 1'b1} src_e;

  logic [EW-1:0] mem_q  [2][DEPTH];
  logic [PW-1:0] wptr_q [2];
  logic [PW-1:0] wptr_d [2];
  logic [PW-1:0] rptr_q [2];
  logic [PW-1:0] rptr_d [2];
  logic [CW-1:0] cnt_q  [2];
  logic [CW-1:0] cnt_d  [2];

  logic          vld    [2];
  logic [AW-1:0] addr   [2];
  logic [DW-1:0] data   [2];
  logic          ready  [2];
  logic          nempty [2];
  logic          push   [2];
  logic          pop    [2];
  logic [EW-1:0] head   [2];

  src_e          last_q, last_d;
  src_e          gnt;
  logic          gnt_vld;
  logic [EW-1:0] sel;

  logic          we_q, we_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [DW-1:0] wd_q, wd_d;

  assign vld[0]  = bus.s0_valid;
  assign vld[1]  = bus.s1_valid;
  assign addr[0] = bus.s0_addr;
  assign addr[1] = bus.s1_addr;
  assign data[0] = bus.s0_data;
  assign data[1] = bus.s1_data;

  // Ready looks only at occupancy: a full FIFO refuses even when it pops this cycle.
  always_comb begin
    for (int unsigned s = 0; s < 2; s++) begin
      nempty[s] = (cnt_q[s] != '0);
      ready[s]  = !rst && (cnt_q[s] != CW'(DEPTH));
      push[s]   = vld[s] && ready[s] && (addr[s] != '0);
      head[s]   = mem_q[s][rptr_q[s]];
    end
  end

  always_comb begin
    gnt_vld = nempty[0] || nempty[1];
    gnt     = SRC0;
`ifdef WB_RR_EN
    if (nempty[0] && nempty[1]) begin
      gnt = (last_q == SRC0) ? SRC1 : SRC0;
    end else if (nempty[1]) begin
      gnt = SRC1;
    end
`else
    if (!nempty[0] && nempty[1]) begin
      gnt = SRC1;
    end
`endif
  end

  always_comb begin
    pop[0] = gnt_vld && (gnt == SRC0);
    pop[1] = gnt_vld && (gnt == SRC1);
    for (int unsigned s = 0; s < 2; s++) begin
      wptr_d[s] = push[s] ? wptr_q[s] + PW'(1) : wptr_q[s];
      rptr_d[s] = pop[s]  ? rptr_q[s] + PW'(1) : rptr_q[s];
      cnt_d[s]  = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
    end
  end

  always_comb begin
    sel    = (gnt == SRC1) ? head[1] : head[0];
    last_d = last_q;
    we_d   = gnt_vld;
    wa_d   = wa_q;
    wd_d   = wd_q;
    if (gnt_vld) begin
      last_d = gnt;
      wa_d   = sel[EW-1:DW];
      wd_d   = sel[DW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < 2; s++) begin
        wptr_q[s] <= '0;
        rptr_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
      last_q <= SRC1;
      we_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
    end else begin
      for (int unsigned s = 0; s < 2; s++) begin
        wptr_q[s] <= wptr_d[s];
        rptr_q[s] <= rptr_d[s];
        cnt_q[s]  <= cnt_d[s];
      end
      last_q <= last_d;
      we_q   <= we_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
    end
  end

  // Storage needs no reset: pointers and counts alone define valid contents.
  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < 2; s++) begin
      if (push[s]) begin
        mem_q[s][wptr_q[s]] <= {addr[s], data[s]};
      end
    end
  end

  assign bus.s0_ready = ready[0];
  assign bus.s1_ready = ready[1];
  assign bus.s0_count = cnt_q[0];
  assign bus.s1_count = cnt_q[1];
  assign bus.we       = we_q;
  assign bus.wa       = wa_q;
  assign bus.wd       = wd_q;
  assign bus.idle     = !nempty[0] && !nempty[1] && !we_q;
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Shares the register file's single write port (`we`/`wa`/`wd`) between two writeback sources: source 0 is the load/memory unit and source 1 is the ALU. Each source pushes writes through a valid/ready handshake into its own in-order FIFO. The arbiter pops one FIFO head per cycle into a registered output stage that drives the register file write port directly. Writes to x0 are accepted and discarded.

## Interface
- `DEPTH`, 4: entries per source FIFO; power of two, ≥2.
- `AW`, 5: register address width.
- `DW`, 32: data width.

- `clk` in 1: clock. One clock domain; all state updates on its rising edge.
- `rst` in 1: reset. Asynchronous, active-high.
- `s0_valid` in 1: source 0 write request.
- `s0_ready` out 1: source 0 FIFO can accept.
- `s0_addr` in AW: source 0 destination register.
- `s0_data` in DW: source 0 write data.
- `s1_valid`, `s1_ready`, `s1_addr`, `s1_data`: same as source 0, for source 1.
- `we` out 1: register file write enable (registered).
- `wa` out AW: register file write address (registered).
- `wd` out DW: register file write data (registered).
- `s0_count` out clog2(DEPTH)+1: source 0 FIFO occupancy.
- `s1_count` out clog2(DEPTH)+1: source 1 FIFO occupancy.
- `idle` out 1: both FIFOs empty and `we`=0.

## Operation
- Reset values:
  - `we`=0, `wa`=0, `wd`=0.
  - FIFO pointers and counts = 0; `idle`=1.
  - Round-robin state `last`=1, so source 0 wins first contention.
  - `sN_ready`=0 while `rst` is high.
- Enqueue:
  - `sN_ready` = !rst && (sN_count != DEPTH), a combinational function of state only.
  - A transfer occurs on the edge where valid && ready.
  - A transfer with addr==0 completes the handshake but is not stored; the count is unchanged.
- Dequeue, evaluated every cycle:
  - Grant a non-empty FIFO.
  - On the next edge, the head entry loads `wa`/`wd`, `we`=1, and that FIFO pops.
  - If neither FIFO is non-empty, `we` goes to 0 on the next edge. `wa`/`wd` hold their last values.
- Arbitration:
  - If only one FIFO is non-empty, it is granted.
  - If both are non-empty, see Configuration.
  - `last` records the granted source on every grant.
- Ordering:
  - Each source's writes reach the port in acceptance order.
  - Cross-source order is the arbitration order. Upstream hazard logic must not issue the same address from both sources while one is pending.
- A simultaneous enqueue and pop on the same FIFO in one edge is legal; the count is unchanged.
- When full, `ready`=0 even if a pop occurs that cycle (no pass-through).
- Pointers wrap modulo DEPTH; counts saturate logically at DEPTH and never exceed it.
- Reset mid-operation:
  - All buffered writes are discarded.
  - An in-flight `we`=1 is cleared immediately (asynchronously), so no register file write occurs at the next edge.

## Timing
- Latency: a write accepted at edge N sits in the FIFO after N. It appears on `we`/`wa`/`wd` after edge N+1, and the register file commits it at edge N+2.
- With contention, a source waits at most 1 extra cycle per queued competing entry under round-robin.
- Throughput: one register file write per cycle sustained. Each source may also enqueue one per cycle while not full.
- Register file write-through bypass makes the data readable during the cycle `we`=1 (cycle N+1→N+2).
- `idle` is combinational from registered state.

## Configuration
- `WB_RR_EN` defined: round-robin on contention. The granted source is the one ≠ `last`; strict alternation occurs while both are non-empty.
- `WB_RR_EN` undefined: fixed priority, source 0 always wins contention. Source 1 is granted only when FIFO 0 is empty. `last` is still maintained but unused.

## Test plan
- Single write, reset then `s1_valid`, addr=5, data=0xDEADBEEF for one cycle: `we`=1, `wa`=5, `wd`=0xDEADBEEF in exactly the second cycle after acceptance, for one cycle; `idle` returns to 1.
- x0 discard, source 0 writes addr=0, data=0x1234: handshake completes, `s0_count` stays 0, `we` never asserts.
- Contention with `WB_RR_EN`, both sources preloaded with 3 entries (s0: r1..r3, s1: r11..r13): port sequence is r1,r11,r2,r12,r3,r13. Without the macro: r1,r2,r3,r11,r12,r13.
- Backpressure with DEPTH=4:
  - Hold `s1_valid` with the port saturated by source 0 under fixed priority.
  - `s1_ready`=0 once `s1_count`=4, including in the cycle a pop occurs.
  - No accepted entry is lost or reordered, and `s1_count` never exceeds 4.
- Wrap-around, 3×DEPTH back-to-back writes from source 0 with incrementing data: all emerge in order with 1-per-cycle throughput after the initial 2-cycle latency.
- Reset mid-operation:
  - Assert `rst` asynchronously (off-edge) while both FIFOs are non-empty and `we`=1.
  - `we` drops before the next edge, counts go to 0, and `sN_ready`=0 during reset.
  - After release, the first contention grants source 0.
